// File: rtl/spn_cu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : spn_cu_iter
//  Description : Iterative SPN crypto unit. One substitution/permutation
//                round per clock over a parametrised block, with valid/ready
//                handshakes on both request and result sides. Encrypt,
//                decrypt and error reporting share one datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module spn_cu_iter #(
    parameter int NIBBLES = 4,     // block width is 4*NIBBLES bits, >= 1
    parameter int ROUNDS  = 3,     // number of SPN rounds, >= 1
    parameter int KEY_W   = 32,    // secret key width, >= 4*NIBBLES
    parameter int ROT     = 2      // P-box left-rotate amount, < 4*NIBBLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           opcode,
    input  logic [4*NIBBLES-1:0] data_in,
    input  logic [KEY_W-1:0]     secret_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] data_out,
    output logic [1:0]           status,
    output logic                 busy
);

    localparam int BLOCK_W = 4 * NIBBLES;
    localparam int CNT_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    // Round-key table is padded to a power of two so any counter value
    // indexes a defined entry.
    localparam int RK_N    = 1 << CNT_W;

    localparam logic [CNT_W-1:0] C_LAST_RND = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] C_FIRST_RND = '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] C_OP_NOP = 2'b00;
    localparam logic [1:0] C_OP_ENC = 2'b01;
    localparam logic [1:0] C_OP_DEC = 2'b10;
    localparam logic [1:0] C_OP_ERR = 2'b11;

    localparam logic [1:0] C_ST_NONE = 2'b00;
    localparam logic [1:0] C_ST_ENC  = 2'b01;
    localparam logic [1:0] C_ST_DEC  = 2'b10;
    localparam logic [1:0] C_ST_ERR  = 2'b11;

    // ------------------------------------------------------------------
    // Substitution tables (4-bit)
    // ------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] s;
        s = 4'h0;
        case (n)
            4'h0: s = 4'hA;
            4'h1: s = 4'h5;
            4'h2: s = 4'h8;
            4'h3: s = 4'h2;
            4'h4: s = 4'h6;
            4'h5: s = 4'hC;
            4'h6: s = 4'h4;
            4'h7: s = 4'h3;
            4'h8: s = 4'h1;
            4'h9: s = 4'h0;
            4'hA: s = 4'hB;
            4'hB: s = 4'h9;
            4'hC: s = 4'hF;
            4'hD: s = 4'hD;
            4'hE: s = 4'h7;
            default: s = 4'hE;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        logic [3:0] s;
        s = 4'h0;
        case (n)
            4'h0: s = 4'h9;
            4'h1: s = 4'h8;
            4'h2: s = 4'h3;
            4'h3: s = 4'h7;
            4'h4: s = 4'h6;
            4'h5: s = 4'h1;
            4'h6: s = 4'h4;
            4'h7: s = 4'hE;
            4'h8: s = 4'h2;
            4'h9: s = 4'hB;
            4'hA: s = 4'h0;
            4'hB: s = 4'hA;
            4'hC: s = 4'h5;
            4'hD: s = 4'hD;
            4'hE: s = 4'hF;
            default: s = 4'hC;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dec;      // 1 = decrypt operation in flight
    logic [BLOCK_W-1:0] r_x;        // working block
    logic [KEY_W-1:0]   r_key;      // key captured at accept

    // ------------------------------------------------------------------
    // Round keys: rk[r] is the low block of the key rotated left by
    // 8*r mod KEY_W. Rotation amounts are elaboration constants, so each
    // entry is pure wiring; only the counter-driven select is logic.
    // ------------------------------------------------------------------
    logic [BLOCK_W-1:0] w_rk [RK_N];
    logic [BLOCK_W-1:0] w_rk_sel;

    for (genvar r = 0; r < RK_N; r++) begin : g_rk
        if (r < ROUNDS) begin : g_used
            localparam int AMT = (8 * r) % KEY_W;
            assign w_rk[r] = BLOCK_W'((r_key << AMT) | (r_key >> (KEY_W - AMT)));
        end else begin : g_pad
            assign w_rk[r] = '0;
        end
    end

    assign w_rk_sel = w_rk[r_cnt];

    // ------------------------------------------------------------------
    // Round datapath. Encrypt: key mix, substitute, rotate left (except
    // in the last round). Decrypt undoes it in the reverse order.
    // ------------------------------------------------------------------
    logic               w_last;
    logic [BLOCK_W-1:0] w_enc_mix;
    logic [BLOCK_W-1:0] w_enc_sub;
    logic [BLOCK_W-1:0] w_enc_next;
    logic [BLOCK_W-1:0] w_dec_perm;
    logic [BLOCK_W-1:0] w_dec_sub;
    logic [BLOCK_W-1:0] w_dec_next;
    logic [BLOCK_W-1:0] w_next;

    assign w_last    = (r_cnt == C_LAST_RND);
    assign w_enc_mix = r_x ^ w_rk_sel;

    for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
        assign w_enc_sub[4*i +: 4] = sbox(w_enc_mix[4*i +: 4]);
        assign w_dec_sub[4*i +: 4] = inv_sbox(w_dec_perm[4*i +: 4]);
    end

    assign w_enc_next = w_last ? w_enc_sub
                               : ((w_enc_sub << ROT) | (w_enc_sub >> (BLOCK_W - ROT)));
    assign w_dec_perm = w_last ? r_x
                               : ((r_x >> ROT) | (r_x << (BLOCK_W - ROT)));
    assign w_dec_next = w_dec_sub ^ w_rk_sel;
    assign w_next     = r_dec ? w_dec_next : w_enc_next;

    // Terminal round: counter has reached the end of its direction of travel.
    logic w_final;
    assign w_final = r_dec ? (r_cnt == C_FIRST_RND) : w_last;

    // ------------------------------------------------------------------
    // Status outputs decoded from state
    // ------------------------------------------------------------------
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);

    // Control FSM, round counter, working block and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dec    <= 1'b0;
            r_x      <= '0;
            r_key    <= '0;
            data_out <= '0;
            status   <= C_ST_NONE;
            in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is registered so it stays low for the
                    // reset-release edge and comes up one cycle later.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        case (opcode)
                            C_OP_ENC: begin
                                r_state  <= S_RUN;
                                r_cnt    <= '0;
                                r_dec    <= 1'b0;
                                r_x      <= data_in;
                                r_key    <= secret_key;
                                in_ready <= 1'b0;
                            end
                            C_OP_DEC: begin
                                r_state  <= S_RUN;
                                r_cnt    <= C_LAST_RND;
                                r_dec    <= 1'b1;
                                r_x      <= data_in;
                                r_key    <= secret_key;
                                in_ready <= 1'b0;
                            end
                            C_OP_ERR: begin
                                r_state  <= S_DONE;
                                data_out <= '0;
                                status   <= C_ST_ERR;
                                in_ready <= 1'b0;
                            end
                            default: begin
                                // NOP is consumed and dropped
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    r_x <= w_next;
                    if (w_final) begin
                        r_state  <= S_DONE;
                        data_out <= w_next;
                        status   <= r_dec ? C_ST_DEC : C_ST_ENC;
                    end else if (r_dec) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result held until the consumer takes it
                    if (out_ready) begin
                        r_state  <= S_IDLE;
                        data_out <= '0;
                        status   <= C_ST_NONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spn_cu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spn_cu_iter
//  Description : Directed self-checking bench for spn_cu_iter. A default
//                instance (a_*) plus a 2-nibble instance (b_*) and a
//                single-round instance (c_*) sharing the control stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spn_cu_iter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  opcode;
    logic [15:0] data_in;
    logic [31:0] secret_key;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [15:0] a_data_out;
    logic [1:0]  a_status;

    logic        b_in_ready, b_out_valid, b_busy;
    logic [7:0]  b_data_out;
    logic [1:0]  b_status;

    logic        c_in_ready, c_out_valid, c_busy;
    logic [15:0] c_data_out;
    logic [1:0]  c_status;

    int vectors = 0;
    int miscompares = 0;

    spn_cu_iter u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .opcode     (opcode),
        .data_in    (data_in),
        .secret_key (secret_key),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .data_out   (a_data_out),
        .status     (a_status),
        .busy       (a_busy)
    );

    spn_cu_iter #(.NIBBLES(2)) u_dut_n2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .opcode     (opcode),
        .data_in    (data_in[7:0]),
        .secret_key (secret_key),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .data_out   (b_data_out),
        .status     (b_status),
        .busy       (b_busy)
    );

    spn_cu_iter #(.ROUNDS(1)) u_dut_r1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (c_in_ready),
        .opcode     (opcode),
        .data_in    (data_in),
        .secret_key (secret_key),
        .out_valid  (c_out_valid),
        .out_ready  (out_ready),
        .data_out   (c_data_out),
        .status     (c_status),
        .busy       (c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to the default instance; returns one cycle after
    // the accepting edge. Inputs are scrambled afterwards on purpose.
    task automatic present(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k);
        int n;
        n = 0;
        while (!a_in_ready && n < 8) begin
            tick();
            n++;
        end
        opcode     = op;
        data_in    = d;
        secret_key = k;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        opcode     = 2'b01;
        data_in    = 16'hA5C3;
        secret_key = 32'hFFFF0000;
    endtask

    // Bounded wait for a result on the default instance.
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!a_out_valid && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = 2'b00; data_in = '0; secret_key = '0;
        tick(); tick();
        vectors++;
        if ({a_in_ready, a_out_valid, a_busy, a_status, a_data_out} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b vld=%b busy=%b st=%b do=%h expected all zero",
                     a_in_ready, a_out_valid, a_busy, a_status, a_data_out);
        end
        reset_n = 1'b1;
        vectors++;
        if (a_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready_early: got %b expected 0", a_in_ready);
        end
        tick();
        vectors++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: got rdy=%b busy=%b expected rdy=1 busy=0", a_in_ready, a_busy);
        end
    endtask

    task automatic test_encrypt_zero();
        present(2'b01, 16'h0000, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            vectors++;
            if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_in_ready !== 1'b0 || a_status !== 2'b00) begin
                miscompares++;
                $display("FAIL enc_latency_run cycle N+%0d: got vld=%b busy=%b rdy=%b st=%b expected 0 1 0 00",
                         i, a_out_valid, a_busy, a_in_ready, a_status);
            end
            tick();
        end
        vectors++;
        if (a_out_valid !== 1'b1 || a_data_out !== 16'h7777 || a_status !== 2'b01) begin
            miscompares++;
            $display("FAIL enc_zero: got vld=%b do=%h st=%b expected 1 7777 01", a_out_valid, a_data_out, a_status);
        end
        tick();
        vectors++;
        if (a_out_valid !== 1'b0 || a_data_out !== 16'h0 || a_status !== 2'b00 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL enc_one_cycle: got vld=%b do=%h st=%b busy=%b expected 0 0000 00 0",
                     a_out_valid, a_data_out, a_status, a_busy);
        end
    endtask

    task automatic test_decrypt_zero();
        int c;
        present(2'b10, 16'h7777, 32'h0);
        wait_done(3, c);
        vectors++;
        if (a_out_valid !== 1'b1 || c !== 3 || a_data_out !== 16'h0000 || a_status !== 2'b10) begin
            miscompares++;
            $display("FAIL dec_zero: got vld=%b cyc=%0d do=%h st=%b expected 1 3 0000 10",
                     a_out_valid, c, a_data_out, a_status);
        end
        tick();
    endtask

    task automatic test_known_key();
        int c;
        present(2'b01, 16'h0000, 32'h12345678);
        wait_done(3, c);
        vectors++;
        if (a_out_valid !== 1'b1 || a_data_out !== 16'h5C6C || a_status !== 2'b01) begin
            miscompares++;
            $display("FAIL enc_key12345678: got vld=%b do=%h st=%b expected 1 5c6c 01", a_out_valid, a_data_out, a_status);
        end
        tick();
        present(2'b10, 16'h5C6C, 32'h12345678);
        wait_done(3, c);
        vectors++;
        if (a_out_valid !== 1'b1 || a_data_out !== 16'h0000 || a_status !== 2'b10) begin
            miscompares++;
            $display("FAIL dec_key12345678: got vld=%b do=%h st=%b expected 1 0000 10", a_out_valid, a_data_out, a_status);
        end
        tick();
    endtask

    task automatic test_error_opcode();
        present(2'b11, 16'h1234, 32'hCAFEF00D);
        vectors++;
        if (a_out_valid !== 1'b1 || a_status !== 2'b11 || a_data_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL err_opcode: got vld=%b st=%b do=%h expected 1 11 0000", a_out_valid, a_status, a_data_out);
        end
        tick();
        vectors++;
        if (a_out_valid !== 1'b0 || a_status !== 2'b00) begin
            miscompares++;
            $display("FAIL err_release: got vld=%b st=%b expected 0 00", a_out_valid, a_status);
        end
    endtask

    task automatic test_nop();
        tick();
        present(2'b00, 16'h5555, 32'h0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL nop_dropped cycle %0d: got vld=%b rdy=%b busy=%b expected 0 1 0",
                         i, a_out_valid, a_in_ready, a_busy);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int c;
        int bad;
        out_ready = 1'b0;
        present(2'b01, 16'h0000, 32'h0);
        wait_done(3, c);
        vectors++;
        if (a_out_valid !== 1'b1 || a_data_out !== 16'h7777 || a_status !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_result: got vld=%b do=%h st=%b expected 1 7777 01", a_out_valid, a_data_out, a_status);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            opcode   = 2'b10;
            data_in  = 16'($urandom);
            tick();
            if (a_out_valid !== 1'b1 || a_data_out !== 16'h7777 || a_status !== 2'b01 || a_in_ready !== 1'b0)
                bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_status !== 2'b00 || a_data_out !== 16'h0) begin
            miscompares++;
            $display("FAIL bp_release: got vld=%b busy=%b st=%b do=%h expected 0 0 00 0000",
                     a_out_valid, a_busy, a_status, a_data_out);
        end
        tick();
        vectors++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle: got rdy=%b busy=%b expected 1 0", a_in_ready, a_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        present(2'b01, 16'h0000, 32'h0);
        tick();                 // now executing round 1
        reset_n = 1'b0;
        tick();
        vectors++;
        if (a_out_valid !== 1'b0 || a_status !== 2'b00 || a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got vld=%b st=%b busy=%b rdy=%b expected 0 00 0 0",
                     a_out_valid, a_status, a_busy, a_in_ready);
        end
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_out_valid !== 1'b0 || a_busy !== 1'b0) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_no_stale: got %0d cycles with result/busy expected 0", seen);
        end
    endtask

    task automatic test_roundtrip();
        int          c;
        int          bad;
        logic [15:0] p;
        logic [15:0] ct;
        logic [31:0] k;
        for (int i = 0; i < 200; i++) begin
            k = $urandom;
            p = 16'($urandom);
            bad = 0;
            present(2'b01, p, k);
            wait_done(3, c);
            if (a_out_valid !== 1'b1 || a_status !== 2'b01) bad++;
            ct = a_data_out;
            tick();
            present(2'b10, ct, k);
            wait_done(3, c);
            if (a_out_valid !== 1'b1 || a_status !== 2'b10 || a_data_out !== p) bad++;
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("FAIL roundtrip key=%h pt=%h: got ct=%h back=%h st=%b expected back=%h st=10",
                         k, p, ct, a_data_out, a_status, p);
            end
            tick();
        end
    endtask

    task automatic test_params();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        present(2'b01, 16'h0000, 32'h0);
        vectors++;
        if (c_out_valid !== 1'b0 || c_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL r1_latency: got vld=%b busy=%b at N+1 expected 0 1", c_out_valid, c_busy);
        end
        tick();
        vectors++;
        if (c_out_valid !== 1'b1 || c_data_out !== 16'hAAAA || c_status !== 2'b01) begin
            miscompares++;
            $display("FAIL r1_enc_zero: got vld=%b do=%h st=%b expected 1 aaaa 01", c_out_valid, c_data_out, c_status);
        end
        tick();
        tick();
        vectors++;
        if (b_out_valid !== 1'b1 || b_data_out !== 8'h77 || b_status !== 2'b01) begin
            miscompares++;
            $display("FAIL n2_enc_zero: got vld=%b do=%h st=%b expected 1 77 01", b_out_valid, b_data_out, b_status);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_encrypt_zero();
        test_decrypt_zero();
        test_known_key();
        test_error_opcode();
        test_nop();
        test_backpressure();
        test_reset_mid_run();
        test_roundtrip();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spn_cu_iter.md
Name: spn_cu_iter

Overview:
- Iterative, parametrised successor to the single-shot SPN crypto unit.
- Performs one SPN round per clock over a configurable block width, round count and key width.
- Uses valid/ready handshakes on both input and output, so it can sit behind a stream source and stall on a busy consumer.
- Encrypt, decrypt and error reporting share one datapath, with a per-operation status code.

Parameters:
- NIBBLES, 4, block width BLOCK_W = 4*NIBBLES bits; must be >= 1.
- ROUNDS, 3, number of SPN rounds; must be >= 1.
- KEY_W, 32, secret key width; must be >= BLOCK_W.
- ROT, 2, P-box left-rotate amount in bits; must be < BLOCK_W.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous reset, active low.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- opcode  input  2  00 nop, 01 encrypt, 10 decrypt, 11 undefined.
- data_in  input  BLOCK_W  plaintext or ciphertext.
- secret_key  input  KEY_W  symmetric key.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- data_out  output  BLOCK_W  result block.
- status  output  2  01 encrypt ok, 10 decrypt ok, 11 error, 00 no result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low (reset_n sampled on clk rising edge).
- Reset values, held while reset_n = 0: state IDLE, round counter 0, out_valid 0, data_out 0, status 00, busy 0, in_ready 0. in_ready rises in the first cycle after reset_n is sampled high.
- States:
  - IDLE: in_ready = 1.
  - RUN: in_ready = 0, busy = 1.
  - DONE: out_valid = 1, busy = 1, in_ready = 0.
- Accept: in IDLE, when in_valid && in_ready at a rising edge, register opcode, data_in and secret_key. Later changes on these inputs are ignored until the next accept.
  - opcode 01 or 10 -> RUN. Counter = 0 for encrypt, ROUNDS-1 for decrypt.
  - opcode 11 -> DONE, with data_out = 0 and status = 11 (latency 1 cycle).
  - opcode 00 -> consumed and dropped; stays in IDLE; no output.
  - in_valid = 0 -> stay in IDLE.
- S-box, indices 0..F: A 5 8 2 6 C 4 3 1 0 B 9 F D 7 E.
- Inverse S-box: 9 8 3 7 6 1 4 E 2 B 0 A 5 D F C.
- Substitution is applied to every nibble independently.
- Round key rk[r] = low BLOCK_W bits of (secret_key rotated left by (8*r mod KEY_W)).
- Encrypt round r:
  - x = x ^ rk[r]; x = S(x).
  - If r != ROUNDS-1, x = rotl(x, ROT).
  - Rounds run with the counter going 0 up to ROUNDS-1.
- Decrypt round r, with the counter going ROUNDS-1 down to 0:
  - If r != ROUNDS-1, x = rotr(x, ROT).
  - x = S^-1(x); x = x ^ rk[r].
- RUN: one round per cycle. After the final round, go to DONE with data_out = x and status = 01 (encrypt) or 10 (decrypt).
- Latency: accept in cycle N gives out_valid = 1 from cycle N+ROUNDS+1.
- DONE: data_out and status are held stable until out_valid && out_ready. On that edge go to IDLE, and out_valid, data_out and status return to 0.
  - out_ready already high on entry to DONE gives exactly one cycle of out_valid.
  - Throughput is one operation per ROUNDS+2 cycles minimum. There is no accept during DONE.
- Outside DONE, data_out = 0 and status = 00.
- Reset mid-RUN or mid-DONE: the operation is abandoned with no output, and all reset values apply on the next edge.
- Round counter width is max(1, $clog2(ROUNDS)). The counter never wraps past its terminal value.
- ROUNDS = 1: a single round with no permutation.

Test Plan:
- Defaults, key 0x00000000, encrypt 0x0000, out_ready = 1 -> out_valid in cycle N+4, data_out = 0x7777, status = 01, one cycle only.
- Decrypt 0x7777 with key 0 -> data_out = 0x0000, status = 10. Then 200 random key/plaintext pairs, encrypt followed by decrypt, must return the plaintext, each within ROUNDS+1 cycles.
- opcode 11 with in_valid -> next cycle out_valid = 1, status = 11, data_out = 0x0000. opcode 00 with in_valid -> no out_valid, in_ready stays 1.
- Backpressure: out_ready = 0 for 10 cycles after out_valid -> data_out and status held stable, in_ready = 0, in_valid ignored. out_ready = 1 -> IDLE next cycle.
- reset_n = 0 for one edge during RUN round 1 -> next cycle IDLE, out_valid = 0, status = 00. No stale result appears afterwards.
- NIBBLES = 2, key 0: encrypt 0x00 -> 0x77. ROUNDS = 1 with default NIBBLES and key 0: encrypt 0x0000 -> 0xAAAA in cycle N+2.
